// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: single-outstanding imem port, priority redirects, and a
// 1-entry output slot backed by a 1-entry hold buffer for decode stalls.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  input  logic        mret,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        flush,
  output logic        misalign
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic        kill_pending;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        slot_free;

  always_comb begin
    raw_target = br_target;
    if (trap)      raw_target = trap_vec;
    else if (mret) raw_target = mepc;
  end

  assign redirect  = trap | mret | br_taken;
  assign target    = {raw_target[31:2], 2'b00};
  assign slot_free = !if_valid || !stall;

  // The request address is the PC itself; a redirect during an unacked
  // request is parked in redirect_pc so the address stays stable.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_BOOT;
      pc           <= RESET_VECTOR;
      redirect_pc  <= RESET_VECTOR;
      kill_pending <= 1'b0;
      hold_pc      <= '0;
      hold_inst    <= NOP_INST;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_inst      <= NOP_INST;
      flush        <= 1'b0;
      misalign     <= 1'b0;
    end else begin
      flush    <= redirect;
      misalign <= redirect && (raw_target[1:0] != 2'b00);
      if (redirect) begin
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end
      case (state)
        S_BOOT: begin
          state <= S_REQ;
          if (redirect) pc <= target;
        end
        S_REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              pc           <= target;
              kill_pending <= 1'b0;
            end else begin
              redirect_pc  <= target;
              kill_pending <= 1'b1;
            end
          end else if (imem_ack && kill_pending) begin
            // Wrong-path data: drop it and start the redirected fetch.
            pc           <= redirect_pc;
            kill_pending <= 1'b0;
            if (!stall) begin
              if_valid <= 1'b0;
              if_inst  <= NOP_INST;
            end
          end else if (imem_ack && slot_free) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_inst  <= imem_rdata;
            pc       <= pc + 32'd4;
          end else if (imem_ack) begin
            hold_pc   <= pc;
            hold_inst <= imem_rdata;
            pc        <= pc + 32'd4;
            state     <= S_HOLD;
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (!stall) begin
            if_valid <= 1'b1;
            if_pc    <= hold_pc;
            if_inst  <= hold_inst;
            state    <= S_REQ;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: configurable-latency memory model, a scoreboard of
// expected presented PCs, a table of redirect vectors, and hand-written corners.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        trap = 1'b0;
  logic [31:0] trap_vec = '0;
  logic        mret = 1'b0;
  logic [31:0] mepc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
  logic        misalign;

  logic        force_ack = 1'b0;
  int          lat = 0;
  int          cnt = 0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];
  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .trap(trap), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_ack   = force_ack | (imem_req && (cnt >= lat));
  assign imem_rdata = imem_ack ? mem(imem_addr) : 32'h0;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) cnt <= 0;
    else                       cnt <= cnt + 1;
  end

  // Record every instruction decode actually consumes.
  always @(negedge clk) begin
    if (rst_n && if_valid && !stall) begin
      obs_pc.push_back(if_pc);
      obs_inst.push_back(if_inst);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    trap = 1'b0; mret = 1'b0; br_taken = 1'b0;
    trap_vec = '0; mepc = '0; br_target = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; force_ack = 1'b0;
    clear_redirect();
    tick(); tick();
    rst_n = 1'b1;
    obs_pc.delete(); obs_inst.delete(); exp_q.delete();
  endtask

  task automatic drain(input string name);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_pc.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: missing instruction, got none expected pc %h", name, e);
      end else begin
        chk({name, " pc"}, obs_pc.pop_front(), e);
        chk({name, " inst"}, obs_inst.pop_front(), mem(e));
      end
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " imem_req"}, imem_req, 0);
    chk({name, " imem_addr"}, imem_addr, 32'h0);
    chk({name, " if_valid"}, if_valid, 0);
    chk({name, " if_pc"}, if_pc, 32'h0);
    chk({name, " if_inst"}, if_inst, NOP);
    chk({name, " flush"}, flush, 0);
    chk({name, " misalign"}, misalign, 0);
  endtask

  typedef struct {
    logic        trap;
    logic [31:0] tv;
    logic        mret;
    logic [31:0] ep;
    logic        br;
    logic [31:0] bt;
    logic        hold;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int flushes;
    logic [31:0] a;

    vt[0] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h300, 1'b0};
    vt[1] = '{1'b1, 32'h80,  1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h80,  1'b0};
    vt[2] = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h200, 1'b0};
    vt[3] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h102, 1'b0, 32'h100, 1'b1};
    vt[4] = '{1'b1, 32'h83,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b1};
    vt[5] = '{1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0};
    vt[6] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};

    // Reset values and zero-wait streaming.
    lat = 0;
    rst_n = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    obs_pc.delete(); obs_inst.delete();
    tick();
    chk("boot req", imem_req, 1);
    chk("boot addr", imem_addr, 32'h0);
    tick();
    chk("stream addr1", imem_addr, 32'h4);
    chk("stream valid", if_valid, 1);
    chk("stream pc0", if_pc, 32'h0);
    tick();
    chk("stream addr2", imem_addr, 32'h8);
    chk("stream pc1", if_pc, 32'h4);
    tick();
    chk("stream pc2", if_pc, 32'h8);
    chk("stream inst2", if_inst, mem(32'h8));

    // Stall three cycles: one fetch parks in the hold buffer, req drops.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall if_pc", if_pc, 32'h8);
      chk("stall if_inst", if_inst, mem(32'h8));
      chk("stall req", imem_req, 0);
    end
    stall = 1'b0;
    tick();
    chk("unstall valid", if_valid, 1);
    chk("unstall held pc", if_pc, 32'hC);
    chk("unstall addr", imem_addr, 32'h10);
    tick();
    chk("unstall next pc", if_pc, 32'h10);
    tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    drain("stall stream");

    // Slow memory, branch while the request is outstanding.
    lat = 3;
    do_reset();
    tick();
    chk("slow req", imem_req, 1);
    tick();
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    clear_redirect();
    chk("slow flush", flush, 1);
    chk("slow addr held", imem_addr, 32'h0);
    chk("slow valid", if_valid, 0);
    flushes = 0;
    for (int i = 0; i < 20 && imem_addr == 32'h0; i++) begin
      tick();
      if (flush) flushes++;
      if (imem_addr == 32'h0) chk("slow req held", imem_req, 1);
    end
    chk("slow extra flush", flushes, 0);
    chk("slow redirect addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    chk("slow first valid", if_valid, 1);
    chk("slow first pc", if_pc, 32'h100);
    for (int i = 0; i < 6; i++) tick();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    drain("slow stream");

    // Redirect table: priority, misalignment, redirect out of hold, wrap.
    lat = 0;
    for (int v = 0; v < 7; v++) begin
      do_reset();
      tick(); tick(); tick();
      if (vt[v].hold) begin
        stall = 1'b1;
        tick(); tick();
        chk("vec hold req", imem_req, 0);
      end
      trap = vt[v].trap; trap_vec = vt[v].tv;
      mret = vt[v].mret; mepc = vt[v].ep;
      br_taken = vt[v].br; br_target = vt[v].bt;
      tick();
      clear_redirect();
      chk($sformatf("vec%0d flush", v), flush, 1);
      chk($sformatf("vec%0d valid", v), if_valid, 0);
      chk($sformatf("vec%0d misalign", v), misalign, vt[v].exp_mis);
      chk($sformatf("vec%0d addr", v), imem_addr, vt[v].exp_addr);
      tick();
      stall = 1'b0;
      chk($sformatf("vec%0d flush off", v), flush, 0);
      chk($sformatf("vec%0d misalign off", v), misalign, 0);
      chk($sformatf("vec%0d if_pc", v), if_pc, vt[v].exp_addr);
      chk($sformatf("vec%0d if_inst", v), if_inst, mem(vt[v].exp_addr));
      a = vt[v].exp_addr + 32'd4;
      chk($sformatf("vec%0d next addr", v), imem_addr, a);
    end

    // Reset during an outstanding request, with an ack inside reset.
    lat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    lat = 3;
    chk("midreset pending req", imem_req, 1);
    rst_n = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk_reset_vals("midreset");
    lat = 0;
    rst_n = 1'b1;
    tick();
    chk("midreset req", imem_req, 1);
    chk("midreset addr", imem_addr, 32'h0);
    tick();
    chk("midreset valid", if_valid, 1);
    chk("midreset pc", if_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
